tick_latency_meter: RTL

//  Far end of the tick-delay interface: measures clock cycles from a start tick to the

---
 rtl/tick_latency_meter_pkg.sv | 9 +
 rtl/tick_latency_stats.sv | 44 ++++
 rtl/tick_latency_meter.sv | 101 ++++++++++
 3 files changed

// File: rtl/tick_latency_meter_pkg.sv
// Shared types for the tick latency meter: controller state encoding and
// the width of the optional timeout statistics counter.
package tick_latency_meter_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} meter_state_t;

  localparam int STATS_CNT_W = 8;

endpackage

// File: rtl/tick_latency_stats.sv
// Min/max/timeout-count tracker fed by accepted measurements.
// Only instantiated when TICK_LATENCY_METER_STATS_EN is defined.
module tick_latency_stats
  import tick_latency_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   accept_i,
  input  logic [CNT_W-1:0]       cycles_i,
  input  logic                   timeout_i,
  input  logic                   clr_i,
  output logic [CNT_W-1:0]       min_cycles_o,
  output logic [CNT_W-1:0]       max_cycles_o,
  output logic [STATS_CNT_W-1:0] n_timeouts_o
);

  // Saturating increment so the timeout count sticks at its maximum.
  function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
    return (v == '1) ? v : v + STATS_CNT_W'(1);
  endfunction

  // Track extremes of good measurements and count timeouts; clear beats acceptance.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      min_cycles_o <= '1;
      max_cycles_o <= '0;
      n_timeouts_o <= '0;
    end else if (clr_i) begin
      min_cycles_o <= '1;
      max_cycles_o <= '0;
      n_timeouts_o <= '0;
    end else if (accept_i) begin
      if (timeout_i) begin
        n_timeouts_o <= sat_inc(n_timeouts_o);
      end else begin
        if (cycles_i < min_cycles_o) min_cycles_o <= cycles_i;
        if (cycles_i > max_cycles_o) max_cycles_o <= cycles_i;
      end
    end
  end

endmodule

// File: rtl/tick_latency_meter.sv
// Measures the cycle distance from a start tick to the returning echo tick
// and hands one result per start to a valid/ready consumer, or reports a
// timeout when no echo shows up. Defining TICK_LATENCY_METER_STATS_EN adds
// min/max/timeout-count statistics ports.
module tick_latency_meter
  import tick_latency_meter_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             echo_i,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [CNT_W-1:0] meas_cycles_o,
  output logic             meas_timeout_o,
  output logic             busy_o
`ifdef TICK_LATENCY_METER_STATS_EN
  ,
  input  logic                   stats_clr_i,
  output logic [CNT_W-1:0]       min_cycles_o,
  output logic [CNT_W-1:0]       max_cycles_o,
  output logic [STATS_CNT_W-1:0] n_timeouts_o
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  meter_state_t     state;
  logic [CNT_W-1:0] count;

  // Controller: count from the start tick, capture on echo or timeout, hold until accepted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= IDLE;
      count          <= '0;
      meas_valid_o   <= 1'b0;
      meas_cycles_o  <= '0;
      meas_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The count starts at 1 so an echo on the very next cycle reads N=1.
          if (start_i) begin
            state <= MEASURE;
            count <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (echo_i) begin
            state          <= REPORT;
            meas_valid_o   <= 1'b1;
            meas_cycles_o  <= count;
            meas_timeout_o <= 1'b0;
          end else if (count == TIMEOUT_C) begin
            state          <= REPORT;
            meas_valid_o   <= 1'b1;
            meas_cycles_o  <= TIMEOUT_C;
            meas_timeout_o <= 1'b1;
          end else if (start_i) begin
            // A fresh start abandons the one in flight.
            count <= CNT_W'(1);
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        REPORT: begin
          if (meas_ready_i) begin
            state          <= IDLE;
            count          <= '0;
            meas_valid_o   <= 1'b0;
            meas_cycles_o  <= '0;
            meas_timeout_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

`ifdef TICK_LATENCY_METER_STATS_EN
  tick_latency_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .accept_i    (meas_valid_o & meas_ready_i),
    .cycles_i    (meas_cycles_o),
    .timeout_i   (meas_timeout_o),
    .clr_i       (stats_clr_i),
    .min_cycles_o(min_cycles_o),
    .max_cycles_o(max_cycles_o),
    .n_timeouts_o(n_timeouts_o)
  );
`endif

endmodule
